wb_ptp_rtc: RTL and testbench



---
 rtl/wb_ptp_rtc.sv | 172 +++++++++++++++++
 tb/tb_wb_ptp_rtc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_ptp_rtc.sv
// wb_ptp_rtc: Wishbone B4 classic slave holding a free-running PTP
// time-of-day clock (32-bit seconds, 30-bit nanoseconds, 24-bit fraction).
// Firmware can snapshot, load and retune the clock through six registers.
// A pps strobe is raised for one cycle each time the seconds roll over.
module wb_ptp_rtc #(
    parameter logic [31:0] INC_DEFAULT = 32'h5355_5555,
    parameter int unsigned NS_PER_SEC  = 1_000_000_000
) (
    input  logic        clock_main,
    input  logic        rst_n,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    output logic        wbs_ack_o,
    output logic        pps_o,
    output logic [31:0] time_sec_o,
    output logic [29:0] time_ns_o
);

    localparam logic [30:0] NS_MOD = 31'(NS_PER_SEC);

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_INC      = 3'd1;
    localparam logic [2:0] REG_SNAP_SEC = 3'd2;
    localparam logic [2:0] REG_SNAP_NS  = 3'd3;
    localparam logic [2:0] REG_LOAD_SEC = 3'd4;
    localparam logic [2:0] REG_LOAD_NS  = 3'd5;

    logic        en;
    logic        err;
    logic [31:0] inc;
    logic [31:0] snap_sec;
    logic [29:0] snap_ns;
    logic [31:0] load_sec;
    logic [29:0] load_ns;
    logic [23:0] frac;

    logic [2:0]  reg_sel;
    logic        access;
    logic        wr;
    logic        wr_ctrl;
    logic        snap_pulse;
    logic        load_pulse;
    logic        load_bad;
    logic [31:0] rdata;
    logic [31:0] inc_merged;
    logic [31:0] lsec_merged;
    logic [31:0] lns_merged;
    logic [24:0] frac_sum;
    logic [30:0] ns_sum;
    logic [30:0] ns_wrap;
    logic        rollover;
    logic        unused_bits;

    // Byte-lane merge of a write into an existing register value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (lanes[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // A request is taken only when ack is low, so each transfer acks once.
    assign reg_sel     = wbs_adr_i[4:2];
    assign access      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr          = access & wbs_we_i;
    assign wr_ctrl     = wr & (reg_sel == REG_CTRL) & wbs_sel_i[0];
    assign snap_pulse  = wr_ctrl & wbs_dat_i[1];
    assign load_pulse  = wr_ctrl & wbs_dat_i[2];
    assign load_bad    = ({1'b0, load_ns} >= NS_MOD);

    assign inc_merged  = merge_bytes(inc, wbs_dat_i, wbs_sel_i);
    assign lsec_merged = merge_bytes(load_sec, wbs_dat_i, wbs_sel_i);
    assign lns_merged  = merge_bytes({2'b00, load_ns}, wbs_dat_i, wbs_sel_i);

    // Fractional carry feeds the nanosecond add in the same cycle.
    assign frac_sum    = {1'b0, frac} + {1'b0, inc[23:0]};
    assign ns_sum      = {1'b0, ns_cur()} + {23'd0, inc[31:24]} + {30'd0, frac_sum[24]};
    assign rollover    = (ns_sum >= NS_MOD);
    assign ns_wrap     = ns_sum - NS_MOD;

    assign unused_bits = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], lns_merged[31:30], ns_wrap[30]};

    function automatic logic [29:0] ns_cur();
        return time_ns_o;
    endfunction

    // Read mux over the register file; unmapped offsets return zero.
    always_comb begin
        rdata = 32'd0;
        case (reg_sel)
            REG_CTRL:     rdata = {28'd0, err, 2'b00, en};
            REG_INC:      rdata = inc;
            REG_SNAP_SEC: rdata = snap_sec;
            REG_SNAP_NS:  rdata = {2'b00, snap_ns};
            REG_LOAD_SEC: rdata = load_sec;
            REG_LOAD_NS:  rdata = {2'b00, load_ns};
            default:      rdata = 32'd0;
        endcase
    end

    // Wishbone handshake: single-cycle ack with read data captured alongside.
    always_ff @(posedge clock_main) begin
        if (!rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
        end else begin
            wbs_ack_o <= access;
            wbs_dat_o <= (access && !wbs_we_i) ? rdata : 32'd0;
        end
    end

    // Register file writes, sticky error flag and coherent snapshot capture.
    always_ff @(posedge clock_main) begin
        if (!rst_n) begin
            en       <= 1'b0;
            err      <= 1'b0;
            inc      <= INC_DEFAULT;
            snap_sec <= 32'd0;
            snap_ns  <= 30'd0;
            load_sec <= 32'd0;
            load_ns  <= 30'd0;
        end else begin
            if (wr_ctrl) en <= wbs_dat_i[0];
            if (wr && reg_sel == REG_INC) inc <= inc_merged;
            if (wr && reg_sel == REG_LOAD_SEC) load_sec <= lsec_merged;
            if (wr && reg_sel == REG_LOAD_NS) load_ns <= lns_merged[29:0];
            // A faulty load sets ERR even if the same write asks to clear it.
            if (load_pulse && load_bad) err <= 1'b1;
            else if (wr_ctrl && wbs_dat_i[3]) err <= 1'b0;
            if (snap_pulse) begin
                snap_sec <= time_sec_o;
                snap_ns  <= time_ns_o;
            end
        end
    end

    // Time-of-day counter: load takes priority over the per-cycle advance.
    always_ff @(posedge clock_main) begin
        if (!rst_n) begin
            time_sec_o <= 32'd0;
            time_ns_o  <= 30'd0;
            frac       <= 24'd0;
            pps_o      <= 1'b0;
        end else begin
            pps_o <= 1'b0;
            if (load_pulse) begin
                time_sec_o <= load_sec;
                time_ns_o  <= load_bad ? 30'd0 : load_ns;
                frac       <= 24'd0;
            end else if (en) begin
                frac <= frac_sum[23:0];
                if (rollover) begin
                    time_ns_o  <= ns_wrap[29:0];
                    time_sec_o <= time_sec_o + 32'd1;
                    pps_o      <= 1'b1;
                end else begin
                    time_ns_o <= ns_sum[29:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_ptp_rtc.sv
// Directed testbench for wb_ptp_rtc: register access, time advance,
// snapshot/load behaviour, error flag, rollover with pps and byte lanes.
module tb_wb_ptp_rtc;

    logic        clock_main = 1'b0;
    logic        rst_n;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_ack_o;
    logic        pps_o;
    logic [31:0] time_sec_o;
    logic [29:0] time_ns_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] rd;

    wb_ptp_rtc dut (
        .clock_main (clock_main),
        .rst_n      (rst_n),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_ack_o  (wbs_ack_o),
        .pps_o      (pps_o),
        .time_sec_o (time_sec_o),
        .time_ns_o  (time_ns_o)
    );

    always #5 clock_main = ~clock_main;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_main);
        #1;
    endtask

    // Issues one transfer and returns 1 time unit after the acking edge.
    task automatic wb_xfer(input logic [2:0] r, input logic we, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] data);
        wbs_adr_i = {27'd0, r, 2'b00};
        wbs_dat_i = d;
        wbs_sel_i = s;
        wbs_we_i  = we;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wbs_ack_o) break;
        end
        check("xfer_ack", {31'd0, wbs_ack_o}, 32'd1);
        data      = wbs_dat_o;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [2:0] r, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(r, 1'b1, d, 4'hF, dummy);
    endtask

    task automatic wb_read(input logic [2:0] r, output logic [31:0] data);
        wb_xfer(r, 1'b0, 32'd0, 4'hF, data);
    endtask

    initial begin
        rst_n     = 1'b0;
        wbs_adr_i = 32'h0300_0000;
        wbs_dat_i = 32'd0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        repeat (3) tick();
        check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_sec", time_sec_o, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_ns", {2'b00, time_ns_o}, 32'd0);
        check("idle_pps", {31'd0, pps_o}, 32'd0);
        wb_read(3'd1, rd);
        check("rst_inc", rd, 32'h5355_5555);
        wb_read(3'd0, rd);
        check("rst_ctrl", rd, 32'h0000_0000);

        // Load near the end of a second with a 100 ns step.
        wb_write(3'd4, 32'd5);
        wb_write(3'd5, 32'd999_999_900);
        wb_write(3'd1, 32'h6400_0000);
        wb_write(3'd0, 32'h5);
        check("load_sec", time_sec_o, 32'd5);
        check("load_ns", {2'b00, time_ns_o}, 32'd999_999_900);
        check("load_pps", {31'd0, pps_o}, 32'd0);
        tick();
        check("roll_ns", {2'b00, time_ns_o}, 32'd0);
        check("roll_sec", time_sec_o, 32'd6);
        check("roll_pps", {31'd0, pps_o}, 32'd1);
        tick();
        check("post_ns", {2'b00, time_ns_o}, 32'd100);
        check("post_pps", {31'd0, pps_o}, 32'd0);

        // Default increment from zero: fraction carries on the 4th step.
        wb_write(3'd0, 32'h0);
        wb_write(3'd1, 32'h5355_5555);
        wb_write(3'd4, 32'h10);
        wb_write(3'd5, 32'd0);
        wb_write(3'd0, 32'h5);
        check("def_ns0", {2'b00, time_ns_o}, 32'd0);
        tick();
        check("def_ns1", {2'b00, time_ns_o}, 32'd83);
        tick();
        check("def_ns2", {2'b00, time_ns_o}, 32'd166);
        tick();
        check("def_ns3", {2'b00, time_ns_o}, 32'd249);
        tick();
        check("def_ns4", {2'b00, time_ns_o}, 32'd333);

        // Snapshot while running (EN kept set in the same write).
        wb_write(3'd1, 32'h6400_0000);
        wb_write(3'd4, 32'd7);
        wb_write(3'd5, 32'd1000);
        wb_write(3'd0, 32'h5);
        wb_write(3'd0, 32'h3);
        check("snap_live", {2'b00, time_ns_o}, 32'd1200);
        wb_read(3'd2, rd);
        check("snap_sec", rd, 32'd7);
        wb_read(3'd3, rd);
        check("snap_ns", rd, 32'd1100);
        check("snap_live2", {2'b00, time_ns_o}, 32'd1600);

        // Out-of-range load sets ERR; clear; set wins over clear.
        wb_write(3'd4, 32'h20);
        wb_write(3'd5, 32'd1_000_000_000);
        wb_write(3'd0, 32'h5);
        check("bad_ns", {2'b00, time_ns_o}, 32'd0);
        check("bad_sec", time_sec_o, 32'h20);
        wb_read(3'd0, rd);
        check("err_set", rd, 32'h9);
        wb_write(3'd0, 32'h9);
        wb_read(3'd0, rd);
        check("err_clr", rd, 32'h1);
        wb_write(3'd0, 32'hD);
        wb_read(3'd0, rd);
        check("err_setwins", rd, 32'h9);

        // Seconds wrap with pps.
        wb_write(3'd4, 32'hFFFF_FFFF);
        wb_write(3'd5, 32'd999_999_950);
        wb_write(3'd0, 32'h9);
        wb_write(3'd0, 32'h5);
        check("wrap_pre_sec", time_sec_o, 32'hFFFF_FFFF);
        tick();
        check("wrap_sec", time_sec_o, 32'd0);
        check("wrap_ns", {2'b00, time_ns_o}, 32'd50);
        check("wrap_pps", {31'd0, pps_o}, 32'd1);
        tick();
        check("wrap_pps_off", {31'd0, pps_o}, 32'd0);
        check("wrap_ns2", {2'b00, time_ns_o}, 32'd150);

        // Byte lane write touches only byte 0.
        wb_xfer(3'd4, 1'b1, 32'hAABB_CCDD, 4'b0001, rd);
        wb_read(3'd4, rd);
        check("sel_byte0", rd, 32'hFFFF_FFDD);
        wb_read(3'd6, rd);
        check("unmapped_rd", rd, 32'd0);

        // Held strobe acks every other cycle.
        tick();
        wbs_adr_i = 32'h0300_0004;
        wbs_we_i  = 1'b0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        tick();
        check("b2b_ack1", {31'd0, wbs_ack_o}, 32'd1);
        check("b2b_dat", wbs_dat_o, 32'h6400_0000);
        tick();
        check("b2b_ack2", {31'd0, wbs_ack_o}, 32'd0);
        tick();
        check("b2b_ack3", {31'd0, wbs_ack_o}, 32'd1);

        // Reset in the middle of a transfer forces ack low.
        wbs_stb_i = 1'b1;
        rst_n     = 1'b0;
        tick();
        check("rst_mid_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("rst_mid_sec", time_sec_o, 32'd0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        rst_n     = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
